// File: rtl/piezo_melody_ctrl.sv
// piezo_melody_ctrl: shares one piezo tone generator between keypad notes and
// a built-in 14-entry melody ROM. All outputs except busy are registered.
// Optional feature macro: PIEZO_MELODY_LOOP_EN. When it is defined, the melody
// repeats until stop, a key press or reset ends it.
module piezo_melody_ctrl #(
  parameter int TICK_DIV = 50000,  // clk cycles per 1 ms tick
  parameter int NOTE_MS  = 250,    // ticks per note unit
  parameter int GAP_MS   = 30      // ticks of silence after each auto-play note
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] key_in,
  input  logic       play,
  input  logic       stop,
  output logic [7:0] tone_sel,
  output logic       busy,
  output logic [3:0] note_idx,
  output logic       done
);

  localparam int TICK_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DUR_MAX = (4 * NOTE_MS > GAP_MS) ? 4 * NOTE_MS : GAP_MS;
  localparam int DUR_W   = $clog2(DUR_MAX + 1);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [DUR_W-1:0]  GAP_LAST  = DUR_W'(GAP_MS - 1);
  localparam logic [3:0]        LAST_IDX  = 4'd13;

  localparam logic [7:0] TONE_C = 8'h01;
  localparam logic [7:0] TONE_D = 8'h02;
  localparam logic [7:0] TONE_E = 8'h04;
  localparam logic [7:0] TONE_F = 8'h08;
  localparam logic [7:0] TONE_G = 8'h10;
  localparam logic [7:0] TONE_A = 8'h20;

  typedef enum logic [1:0] {IDLE, MANUAL, NOTE, GAP} state_t;

  // Melody ROM: {len[1:0], tone[7:0]}; a note lasts (len+1) note units.
  function automatic logic [9:0] rom_entry(input logic [3:0] idx);
    case (idx)
      4'd0:    rom_entry = {2'd0, TONE_C};
      4'd1:    rom_entry = {2'd0, TONE_C};
      4'd2:    rom_entry = {2'd0, TONE_G};
      4'd3:    rom_entry = {2'd0, TONE_G};
      4'd4:    rom_entry = {2'd0, TONE_A};
      4'd5:    rom_entry = {2'd0, TONE_A};
      4'd6:    rom_entry = {2'd1, TONE_G};
      4'd7:    rom_entry = {2'd0, TONE_F};
      4'd8:    rom_entry = {2'd0, TONE_F};
      4'd9:    rom_entry = {2'd0, TONE_E};
      4'd10:   rom_entry = {2'd0, TONE_E};
      4'd11:   rom_entry = {2'd0, TONE_D};
      4'd12:   rom_entry = {2'd0, TONE_D};
      4'd13:   rom_entry = {2'd1, TONE_C};
      default: rom_entry = {2'd0, 8'h00};
    endcase
  endfunction

  // Last duration-counter value (in ticks) for a note of the given length.
  function automatic logic [DUR_W-1:0] note_last(input logic [1:0] len);
    case (len)
      2'd0:    note_last = DUR_W'(NOTE_MS - 1);
      2'd1:    note_last = DUR_W'(2 * NOTE_MS - 1);
      2'd2:    note_last = DUR_W'(3 * NOTE_MS - 1);
      default: note_last = DUR_W'(4 * NOTE_MS - 1);
    endcase
  endfunction

  state_t            state_q, state_d;
  logic [TICK_W-1:0] tick_cnt, tick_d;
  logic [DUR_W-1:0]  dur_cnt, dur_d, dur_last;
  logic [7:0]        tone_d;
  logic [3:0]        idx_d, idx_inc;
  logic              done_d;
  logic              key_any, key_onehot, tick;
  logic [9:0]        cur_entry, next_entry;

  assign key_any    = (key_in != 8'd0);
  assign key_onehot = key_any && ((key_in & (key_in - 8'd1)) == 8'd0);
  assign tick       = (tick_cnt == TICK_LAST);
  assign idx_inc    = note_idx + 4'd1;
  assign cur_entry  = rom_entry(note_idx);
  assign next_entry = rom_entry(idx_inc);
  assign dur_last   = (state_q == NOTE) ? note_last(cur_entry[9:8]) : GAP_LAST;
  assign busy       = (state_q == NOTE) || (state_q == GAP);

  // Next-state and next-output logic for the sequencer/arbiter.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d = state_q;
    tone_d  = tone_sel;
    idx_d   = note_idx;
    done_d  = 1'b0;
    dur_d   = dur_cnt;
    tick_d  = tick ? '0 : tick_cnt + TICK_W'(1);

    case (state_q)
      IDLE: begin
        tone_d = 8'd0;
        idx_d  = 4'd0;
        dur_d  = '0;
        if (key_any) begin
          state_d = MANUAL;
          tone_d  = key_onehot ? key_in : 8'd0;
        end else if (play && !stop) begin
          state_d = NOTE;
          tone_d  = rom_entry(4'd0)[7:0];
          tick_d  = '0;  // realign the tick so the first note is exact
        end
      end

      MANUAL: begin
        if (!key_any) begin
          state_d = IDLE;
          tone_d  = 8'd0;
        end else begin
          tone_d = key_onehot ? key_in : 8'd0;
        end
      end

      NOTE, GAP: begin
        if (stop || key_any) begin
          // Abort without done; a held key is picked up from IDLE next cycle.
          state_d = IDLE;
          tone_d  = 8'd0;
          idx_d   = 4'd0;
          dur_d   = '0;
        end else if (tick) begin
          if (dur_cnt == dur_last) begin
            dur_d = '0;
            if (state_q == NOTE) begin
              state_d = GAP;
              tone_d  = 8'd0;
            end else if (note_idx < LAST_IDX) begin
              state_d = NOTE;
              idx_d   = idx_inc;
              tone_d  = next_entry[7:0];
            end else begin
              done_d = 1'b1;
              idx_d  = 4'd0;
`ifdef PIEZO_MELODY_LOOP_EN
              state_d = NOTE;
              tone_d  = rom_entry(4'd0)[7:0];
`else
              state_d = IDLE;
              tone_d  = 8'd0;
`endif
            end
          end else begin
            dur_d = dur_cnt + DUR_W'(1);
          end
        end
      end

      default: begin
        state_d = IDLE;
        tone_d  = 8'd0;
        idx_d   = 4'd0;
        dur_d   = '0;
      end
    endcase
  end

  // State, counter and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge.
    if (rst) begin
      state_q  <= IDLE;
      tick_cnt <= '0;
      dur_cnt  <= '0;
      tone_sel <= 8'd0;
      note_idx <= 4'd0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      tick_cnt <= tick_d;
      dur_cnt  <= dur_d;
      tone_sel <= tone_d;
      note_idx <= idx_d;
      done     <= done_d;
    end
  end

endmodule

// File: tb/tb_piezo_melody_ctrl.sv
// Directed bench for piezo_melody_ctrl with TICK_DIV=4, NOTE_MS=3, GAP_MS=1:
// a len0 note lasts 12 cycles and each gap 4 cycles.
// Define PIEZO_MELODY_LOOP_EN for both bench and RTL to check loop mode.
module tb_piezo_melody_ctrl;

  localparam int TICK_DIV = 4;
  localparam int NOTE_MS  = 3;
  localparam int GAP_MS   = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] key_in;
  logic       play;
  logic       stop;
  logic [7:0] tone_sel;
  logic       busy;
  logic [3:0] note_idx;
  logic       done;

  int t      = 0;  // cycles since the cycle in which play was driven
  int total  = 0;
  int passes = 0;

  piezo_melody_ctrl #(
    .TICK_DIV(TICK_DIV),
    .NOTE_MS (NOTE_MS),
    .GAP_MS  (GAP_MS)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .key_in  (key_in),
    .play    (play),
    .stop    (stop),
    .tone_sel(tone_sel),
    .busy    (busy),
    .note_idx(note_idx),
    .done    (done)
  );

  always #5 clk = ~clk;

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic run_to(input int target);
    while (t < target) step();
  endtask

  // Drive play for one cycle T; on return we are in cycle T+1 with t=1.
  task automatic start_play();
    play = 1'b1;
    t    = 0;
    step();
    play = 1'b0;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  initial begin
    rst    = 1'b1;
    play   = 1'b0;
    stop   = 1'b0;
    key_in = 8'd0;

    // Reset values.
    #12;
    check("rst_tone", tone_sel, 8'h00);
    check("rst_busy", 8'(busy), 8'h00);
    check("rst_idx",  8'(note_idx), 8'h00);
    check("rst_done", 8'(done), 8'h00);
    #1 rst = 1'b0;
    step();
    step();

    // Manual notes from IDLE.
    key_in = 8'h10;
    step();
    check("man_tone_1st", tone_sel, 8'h10);
    check("man_busy", 8'(busy), 8'h00);
    play = 1'b1;  // ignored in MANUAL
    step();
    play = 1'b0;
    repeat (18) step();
    check("man_tone_held", tone_sel, 8'h10);
    check("man_play_ign", 8'(busy), 8'h00);
    key_in = 8'h00;
    step();
    check("man_release", tone_sel, 8'h00);
    step();
    key_in = 8'h11;
    step();
    check("man_two_keys", tone_sel, 8'h00);
    check("man_two_busy", 8'(busy), 8'h00);
    key_in = 8'h00;
    step();
    step();

    // Full song.
    start_play();
    check("song_t1_tone", tone_sel, 8'h01);
    check("song_t1_busy", 8'(busy), 8'h01);
    check("song_t1_idx",  8'(note_idx), 8'h00);
    run_to(5);
    play = 1'b1;  // ignored while playing
    step();
    play = 1'b0;
    check("song_play_ign_idx", 8'(note_idx), 8'h00);
    run_to(12);
    check("song_t12_tone", tone_sel, 8'h01);
    run_to(13);
    check("song_t13_gap", tone_sel, 8'h00);
    check("song_t13_busy", 8'(busy), 8'h01);
    run_to(16);
    check("song_t16_gap", tone_sel, 8'h00);
    run_to(17);
    check("song_t17_tone", tone_sel, 8'h01);
    check("song_t17_idx", 8'(note_idx), 8'h01);
    run_to(33);
    check("song_t33_tone", tone_sel, 8'h10);
    check("song_t33_idx", 8'(note_idx), 8'h02);
    run_to(120);
    check("song_long_end", tone_sel, 8'h10);
    check("song_long_idx", 8'(note_idx), 8'h06);
    run_to(121);
    check("song_long_gap", tone_sel, 8'h00);
    run_to(125);
    check("song_t125_tone", tone_sel, 8'h08);
    check("song_t125_idx", 8'(note_idx), 8'h07);
    run_to(221);
    check("song_last_tone", tone_sel, 8'h01);
    check("song_last_idx", 8'(note_idx), 8'h0d);
    run_to(248);
    check("song_t248_done", 8'(done), 8'h00);
    check("song_t248_busy", 8'(busy), 8'h01);
    check("song_t248_tone", tone_sel, 8'h00);
    run_to(249);
    check("song_t249_done", 8'(done), 8'h01);
    check("song_t249_idx", 8'(note_idx), 8'h00);
`ifdef PIEZO_MELODY_LOOP_EN
    check("loop_t249_busy", 8'(busy), 8'h01);
    check("loop_t249_tone", tone_sel, 8'h01);
    run_to(250);
    check("loop_t250_done", 8'(done), 8'h00);
    check("loop_t250_busy", 8'(busy), 8'h01);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("loop_stop_busy", 8'(busy), 8'h00);
`else
    check("song_t249_busy", 8'(busy), 8'h00);
    check("song_t249_tone", tone_sel, 8'h00);
    run_to(250);
    check("song_t250_done", 8'(done), 8'h00);
`endif
    step();

    // Reset asserted mid-note.
    start_play();
    run_to(20);
    check("mid_idx", 8'(note_idx), 8'h01);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_tone", tone_sel, 8'h00);
    check("mid_rst_busy", 8'(busy), 8'h00);
    check("mid_rst_idx",  8'(note_idx), 8'h00);
    check("mid_rst_done", 8'(done), 8'h00);
    #2 rst = 1'b0;
    step();

    // Key press during note 3 aborts playback.
    start_play();
    run_to(50);
    check("abort_idx", 8'(note_idx), 8'h03);
    check("abort_pre_tone", tone_sel, 8'h10);
    key_in = 8'h02;
    step();
    check("abort_busy", 8'(busy), 8'h00);
    check("abort_done", 8'(done), 8'h00);
    check("abort_silent", tone_sel, 8'h00);
    step();
    check("abort_key_tone", tone_sel, 8'h02);
    check("abort_key_done", 8'(done), 8'h00);
    key_in = 8'h00;
    step();
    step();

    // play and stop together in IDLE: stop wins.
    play = 1'b1;
    stop = 1'b1;
    step();
    play = 1'b0;
    stop = 1'b0;
    check("ps_busy", 8'(busy), 8'h00);
    check("ps_tone", tone_sel, 8'h00);
    step();
    check("ps_busy_later", 8'(busy), 8'h00);

    // stop during note 5.
    start_play();
    run_to(85);
    check("stop_pre_idx", 8'(note_idx), 8'h05);
    check("stop_pre_tone", tone_sel, 8'h20);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("stop_tone", tone_sel, 8'h00);
    check("stop_idx",  8'(note_idx), 8'h00);
    check("stop_busy", 8'(busy), 8'h00);
    check("stop_done", 8'(done), 8'h00);
    step();
    check("stop_done_later", 8'(done), 8'h00);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/piezo_melody_ctrl.md
Name: piezo_melody_ctrl

Overview:
- Sequencer and arbiter in front of the piezo tone generator.
- Shares the single tone generator between the keypad (manual notes) and a built-in melody ROM (auto-play).
- Drives the tone generator's 8-bit one-hot note select.
- Sits between the keypad scanner's key_data[7:0] and the tone generator's key input.

Parameters:
- TICK_DIV, 50000: clk cycles per 1 ms timing tick.
- NOTE_MS, 250: duration of one note unit, in ticks.
- GAP_MS, 30: silent gap after every auto-play note, in ticks.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous active-high reset.
- key_in  input  8  one-hot note from keypad: bit0=C … bit6=B, bit7=high C; 0 = no key.
- play  input  1  single-cycle request to start auto-play.
- stop  input  1  single-cycle request to abort auto-play.
- tone_sel  output  8  registered one-hot note to the tone generator; 0 = silent.
- busy  output  1  high while auto-play is running (NOTE or GAP).
- note_idx  output  4  index of the current ROM entry.
- done  output  1  one-cycle pulse when auto-play completes normally.

Behaviour:
- Reset (async, rst=1): state=IDLE, tone_sel=0, busy=0, note_idx=0, done=0, all counters 0.
- ROM: 14 entries of {len[1:0], tone[7:0]}.
  - Note duration = (len+1)*NOTE_MS ticks.
  - Contents, index 0..13: C,C,G,G,A,A,G(len1),F,F,E,E,D,D,C(len1). All other entries use len0.
- Tick: divider counts 0..TICK_DIV-1 and pulses at terminal count. The divider clears when play is accepted, so the first note's duration is exact.
- States: IDLE, MANUAL, NOTE, GAP.
- Priority within a cycle, highest first:
  1. stop
  2. key_in≠0
  3. play
- IDLE:
  - key_in≠0 → MANUAL.
  - play (and no key) → NOTE with note_idx=0.
  - tone_sel=0.
- MANUAL:
  - tone_sel=key_in if key_in has exactly one bit set, else 0.
  - Returns to IDLE the cycle after key_in==0, with tone_sel=0.
  - play and stop are ignored.
- NOTE:
  - tone_sel=ROM[note_idx].tone for exactly (len+1)*NOTE_MS*TICK_DIV clk cycles, then → GAP.
- GAP:
  - tone_sel=0 for exactly GAP_MS*TICK_DIV cycles.
  - If note_idx<13: note_idx+1, → NOTE.
  - If note_idx==13: → IDLE, done=1 for one cycle, note_idx=0.
- Latency: play accepted at cycle T → tone_sel=ROM[0] and busy=1 from T+1.
- stop in NOTE/GAP: next cycle IDLE, tone_sel=0, busy=0, note_idx=0, no done pulse. stop in IDLE or MANUAL is ignored.
- key_in≠0 during NOTE/GAP: playback aborts as for stop (no done), then → MANUAL. The key tone appears the following cycle.
- play during NOTE/GAP: ignored, no restart.
- Simultaneous play+stop in IDLE: stop wins and play is ignored.
- Reset mid-song: immediate silence, all registers return to reset values.
- Counter widths: tick counter ≥ clog2(TICK_DIV); duration counter ≥ clog2(4*NOTE_MS+1). No wrap is permitted within a note.

Optional Feature:
- Macro: PIEZO_MELODY_LOOP_EN.
- Defined: after the gap of entry 13, note_idx wraps to 0 and playback continues in NOTE. done pulses once per completed pass and busy stays 1. Only stop, a key press or reset end playback.
- Undefined: playback ends in IDLE after entry 13, as described above.

Test Plan:
All scenarios use TICK_DIV=4, NOTE_MS=3, GAP_MS=1.
1. Reset asserted mid-NOTE → same cycle tone_sel=0, busy=0, note_idx=0, done=0.
2. Pulse play at T (no key) → tone_sel=8'h01 over T+1..T+12; 0 over T+13..T+16; 8'h01 from T+17; done pulses at T+249 and busy falls at T+249 (16 units*12 + 14 gaps*4 = 248 cycles).
3. key_in=8'h10 in IDLE, held 20 cycles → tone_sel=8'h10 one cycle later and held; key_in=0 → tone_sel=0 next cycle. key_in=8'h11 → tone_sel=0.
4. During note_idx=3, key_in=8'h02 → next cycle busy=0, no done; following cycle tone_sel=8'h02.
5. play and stop in the same cycle from IDLE → remains IDLE, busy=0. stop at note_idx=5 → next cycle tone_sel=0, note_idx=0, no done.
6. With PIEZO_MELODY_LOOP_EN defined: play → done at T+249, busy stays 1, tone_sel=8'h01 from T+249, note_idx=0.
